// File: rtl/min_pkg.sv
// min_pkg -- definitions shared by the 4-input minimum finder datapath.
//   WIDTH_DEF : default sample width
//   LANES     : samples per packed group
//   PAD_VAL   : filler for unfilled lanes (max unsigned, so it never wins a min)
//   fill_t    : assembly fill state, FILL0..FILL3 = samples currently held
package min_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int LANES     = 4;
   localparam logic [0:WIDTH_DEF-1] PAD_VAL = {WIDTH_DEF{1'b1}};

   typedef enum logic [1:0] {
      FILL0 = 2'd0,
      FILL1 = 2'd1,
      FILL2 = 2'd2,
      FILL3 = 2'd3
   } fill_t;

endpackage

// File: rtl/lane_reg_en.sv
// lane_reg_en -- WIDTH-bit register with load enable and synchronous active-high
// reset to zero. Used for both the assembly lanes and the output lanes of the packer.
//   clk  : clock
//   rst  : synchronous reset, clears q
//   en   : load d on the next rising edge
//   d    : data in
//   q    : registered data out
module lane_reg_en #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [0:WIDTH-1] d,
   output logic [0:WIDTH-1] q
);

   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/min_quad_packer.sv
// min_quad_packer -- packs a serial valid/ready sample stream into groups of four
// (a = oldest .. d = newest) and holds each group on a valid/ready output register
// feeding the min-finder. One sample per cycle sustained, no bubbles.
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : upstream sample and its valid
//   in_ready            : sample accepted this cycle when in_valid & in_ready
//   flush               : (PACK_FLUSH_EN only) emit partial group padded with PAD_VAL
//   a,b,c,d / out_valid : packed group and its valid, held stable while stalled
//   out_ready           : downstream takes the group this cycle
// Build option: define PACK_FLUSH_EN to add the flush port and padded partial groups.
module min_quad_packer
   import min_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [0:WIDTH-1] in_data,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef PACK_FLUSH_EN
   input  logic             flush,
`endif
   output logic [0:WIDTH-1] a,
   output logic [0:WIDTH-1] b,
   output logic [0:WIDTH-1] c,
   output logic [0:WIDTH-1] d,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [0:WIDTH-1] PAD = {WIDTH{1'b1}};

   fill_t count;
   logic  slot_free, accept, emit, flush_fire;

   logic [LANES-2:0][0:WIDTH-1] asm_q;
   logic [LANES-1:0][0:WIDTH-1] out_d, out_q;

   assign slot_free = !out_valid | out_ready;

`ifdef PACK_FLUSH_EN
   // While flushing, in_ready doubles as the flush acknowledge, so it waits only
   // on the output slot regardless of the fill level.
   assign in_ready   = !rst & (flush ? slot_free : ((count != FILL3) | slot_free));
   assign flush_fire = flush & slot_free & ((count != FILL0) | in_valid);
`else
   assign in_ready   = !rst & ((count != FILL3) | slot_free);
   assign flush_fire = 1'b0;
`endif

   assign accept = in_valid & in_ready;
   assign emit   = (accept & (count == FILL3)) | flush_fire;

   // Assembly lanes: lane n captures the sample accepted while holding n samples.
   for (genvar i = 0; i < LANES-1; i++) begin : g_asm
      lane_reg_en #(.WIDTH(WIDTH)) u_asm (
         .clk (clk),
         .rst (rst),
         .en  (accept & (count == fill_t'(i))),
         .d   (in_data),
         .q   (asm_q[i])
      );
   end

   // Output lane source: held samples below the fill level, the incoming sample
   // at the fill level, padding above it. A normal full group is the count==3 case
   // with in_valid set, so one mux serves both full and flushed groups.
   for (genvar i = 0; i < LANES; i++) begin : g_out
      if (i < LANES-1) begin : g_held
         assign out_d[i] = (count > fill_t'(i))                ? asm_q[i] :
                           ((count == fill_t'(i)) && in_valid) ? in_data  : PAD;
      end else begin : g_last
         assign out_d[i] = ((count == FILL3) && in_valid) ? in_data : PAD;
      end

      lane_reg_en #(.WIDTH(WIDTH)) u_out (
         .clk (clk),
         .rst (rst),
         .en  (emit),
         .d   (out_d[i]),
         .q   (out_q[i])
      );
   end

   assign a = out_q[0];
   assign b = out_q[1];
   assign c = out_q[2];
   assign d = out_q[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= FILL0;
         out_valid <= 1'b0;
      end else begin
         if (emit)        count <= FILL0;
         else if (accept) count <= fill_t'(count + 2'd1);

         // A new group overrides a drain in the same cycle.
         if (emit)           out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;
      end
   end

endmodule
